tournament_ghr_bp: RTL and testbench

TOURNAMENT_GHR_BP -- requirements
Module: tournament_ghr_bp

---
 rtl/bp_pkg.sv | 40 ++++
 rtl/sat_ctr_table.sv | 39 +++
 rtl/tournament_ghr_bp.sv | 164 ++++++++++++++++
 tb/tb_tournament_ghr_bp.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the tournament branch predictor.
// Struct fields are sized for the largest supported configuration; modules use the low bits.
package bp_pkg;

   localparam int unsigned BP_MAX_IDX = 16;
   localparam int unsigned BP_MAX_CTR = 4;
   localparam int unsigned BP_MAX_GHR = 16;

   // Accepted update plus the counter values it read (already bypassed)
   typedef struct packed {
      logic                  taken;
      logic                  gtaken;
      logic                  ltaken;
      logic [BP_MAX_IDX-1:0] gidx;
      logic [BP_MAX_IDX-1:0] lidx;
      logic [BP_MAX_CTR-1:0] gctr;
      logic [BP_MAX_CTR-1:0] lctr;
      logic [BP_MAX_CTR-1:0] cctr;
   } bp_upd_t;

   typedef struct packed {
      logic [BP_MAX_GHR-1:0] ghr;
      logic                  gtaken;
      logic                  ltaken;
   } bp_pred_meta_t;

   function automatic logic [BP_MAX_CTR-1:0] ctr_init(input int unsigned bits);
      return BP_MAX_CTR'((1 << (bits - 1)) - 1);
   endfunction

   function automatic logic [BP_MAX_CTR-1:0] ctr_step(input logic [BP_MAX_CTR-1:0] ctr,
                                                      input logic up,
                                                      input int unsigned bits);
      logic [BP_MAX_CTR-1:0] top;
      top = BP_MAX_CTR'((1 << bits) - 1);
      if (up) return (ctr == top) ? ctr : ctr + 1'b1;
      return (ctr == '0) ? ctr : ctr - 1'b1;
   endfunction

endpackage

// File: rtl/sat_ctr_table.sv
// Array of saturating counters: several combinational read ports, one write port,
// and a clear port that takes priority over the write port.
module sat_ctr_table
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES  = 256,
   parameter int unsigned CTR_BITS = 2,
   parameter int unsigned N_RD     = 3
) (
   input  logic                                    clk_i,
   input  logic [N_RD-1:0][$clog2(ENTRIES)-1:0]    rd_idx_i,
   output logic [N_RD-1:0][CTR_BITS-1:0]           rd_data_o,
   input  logic                                    wr_en_i,
   input  logic [$clog2(ENTRIES)-1:0]              wr_idx_i,
   input  logic [CTR_BITS-1:0]                     wr_data_i,
   input  logic                                    clr_en_i,
   input  logic [$clog2(ENTRIES)-1:0]              clr_idx_i
);

   localparam logic [BP_MAX_CTR-1:0] CLR_WIDE = ctr_init(CTR_BITS);
   localparam logic [CTR_BITS-1:0]   CLR_VAL  = CLR_WIDE[CTR_BITS-1:0];

   logic [CTR_BITS-1:0] mem_q [ENTRIES];

   always_ff @(posedge clk_i) begin
      if (clr_en_i) begin
         mem_q[clr_idx_i] <= CLR_VAL;
      end else if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_RD; i++) begin
         rd_data_o[i] = mem_q[rd_idx_i[i]];
      end
   end

endmodule

// File: rtl/tournament_ghr_bp.sv
// Tournament predictor: gshare-style global PHT, PC-indexed local PHT and chooser,
// speculative global history, and a two-stage read/write update pipeline.
module tournament_ghr_bp
   import bp_pkg::*;
#(
   parameter int unsigned VLEN            = 64,
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned GHR_BITS        = 8,
   parameter int unsigned ENTRIES         = 256,
   parameter int unsigned CTR_BITS        = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_bp_i,
   input  logic                       debug_mode_i,
   input  logic [VLEN-1:0]            vpc_i,
   input  logic                       pred_fire_i,
   input  logic                       pred_taken_i,
   output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
   output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
   output logic [GHR_BITS-1:0]        pred_ghr_o,
   output logic [INSTR_PER_FETCH-1:0] pred_gtaken_o,
   output logic [INSTR_PER_FETCH-1:0] pred_ltaken_o,
   input  logic                       upd_valid_i,
   output logic                       upd_ready_o,
   input  logic [VLEN-1:0]            upd_pc_i,
   input  logic                       upd_taken_i,
   input  logic                       upd_mispredict_i,
   input  logic [GHR_BITS-1:0]        upd_ghr_i,
   input  logic                       upd_gtaken_i,
   input  logic                       upd_ltaken_i
);

   localparam int unsigned IW  = $clog2(ENTRIES);
   localparam int unsigned NRD = INSTR_PER_FETCH + 1;
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [IW-1:0]       clr_idx_q, clr_idx_d;
   logic [GHR_BITS-1:0] ghr_q, ghr_d;
   logic                s1_vld_q, s1_vld_d;
   bp_upd_t             s1_q, s1_d;

   logic [NRD-1:0][IW-1:0]       g_rd_idx, l_rd_idx;
   logic [NRD-1:0][CTR_BITS-1:0] g_rd, l_rd, c_rd;
   logic [IW-1:0]               u_lidx, u_gidx;
   logic [BP_MAX_CTR-1:0]       g_nxt, l_nxt, c_nxt;
   logic                        upd_take, wr_en, clr_en;
   logic                        unused_bits;

   assign unused_bits = ^{vpc_i[VLEN-1:IW+1], vpc_i[0], upd_pc_i[VLEN-1:IW+1], upd_pc_i[0]};

   assign u_lidx = upd_pc_i[IW:1];
   assign u_gidx = u_lidx ^ IW'(upd_ghr_i);

   // Slot i PC is vpc+2i, so its index is simply the base index plus i
   always_comb begin
      logic [IW-1:0] li;
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
         li          = vpc_i[IW:1] + IW'(i);
         l_rd_idx[i] = li;
         g_rd_idx[i] = li ^ IW'(ghr_q);
      end
      l_rd_idx[INSTR_PER_FETCH] = u_lidx;
      g_rd_idx[INSTR_PER_FETCH] = u_gidx;
   end

   always_comb begin
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
         pred_gtaken_o[i] = g_rd[i][CTR_BITS-1];
         pred_ltaken_o[i] = l_rd[i][CTR_BITS-1];
         pred_taken_o[i]  = c_rd[i][CTR_BITS-1] ? g_rd[i][CTR_BITS-1] : l_rd[i][CTR_BITS-1];
      end
   end

   assign pred_valid_o = {INSTR_PER_FETCH{state_q == ST_RUN}};
   assign pred_ghr_o   = ghr_q;
   assign upd_ready_o  = (state_q == ST_RUN);
   assign upd_take     = upd_valid_i & upd_ready_o & ~debug_mode_i & ~flush_bp_i;
   assign wr_en        = s1_vld_q & ~flush_bp_i;
   assign clr_en       = (state_q == ST_CLEAR);

   always_comb begin
      g_nxt = ctr_step(s1_q.gctr, s1_q.taken, CTR_BITS);
      l_nxt = ctr_step(s1_q.lctr, s1_q.taken, CTR_BITS);
      c_nxt = s1_q.cctr;
      if (s1_q.gtaken != s1_q.ltaken) begin
         c_nxt = ctr_step(s1_q.cctr, s1_q.gtaken == s1_q.taken, CTR_BITS);
      end
   end

   // Stage-1 read forwards the value stage 2 is writing this cycle
   always_comb begin
      s1_d        = s1_q;
      s1_d.taken  = upd_taken_i;
      s1_d.gtaken = upd_gtaken_i;
      s1_d.ltaken = upd_ltaken_i;
      s1_d.gidx   = BP_MAX_IDX'(u_gidx);
      s1_d.lidx   = BP_MAX_IDX'(u_lidx);
      s1_d.gctr   = (s1_vld_q && s1_q.gidx == BP_MAX_IDX'(u_gidx)) ? g_nxt
                                                                 : BP_MAX_CTR'(g_rd[INSTR_PER_FETCH]);
      s1_d.lctr   = (s1_vld_q && s1_q.lidx == BP_MAX_IDX'(u_lidx)) ? l_nxt
                                                                 : BP_MAX_CTR'(l_rd[INSTR_PER_FETCH]);
      s1_d.cctr   = (s1_vld_q && s1_q.lidx == BP_MAX_IDX'(u_lidx)) ? c_nxt
                                                                 : BP_MAX_CTR'(c_rd[INSTR_PER_FETCH]);
      s1_vld_d    = upd_take;
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      ghr_d     = ghr_q;
      if (flush_bp_i) begin
         state_d   = ST_CLEAR;
         clr_idx_d = '0;
         ghr_d     = '0;
      end else if (state_q == ST_CLEAR) begin
         clr_idx_d = clr_idx_q + 1'b1;
         if (clr_idx_q == IW'(ENTRIES - 1)) state_d = ST_RUN;
      end else if (upd_take && upd_mispredict_i) begin
         ghr_d = {upd_ghr_i[GHR_BITS-2:0], upd_taken_i};
      end else if (pred_fire_i && !debug_mode_i) begin
         ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= '0;
         ghr_q     <= '0;
         s1_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ghr_q     <= ghr_d;
         s1_vld_q  <= s1_vld_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (upd_take) s1_q <= s1_d;
   end

   sat_ctr_table #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .N_RD(NRD)) u_gpht (
      .clk_i(clk_i), .rd_idx_i(g_rd_idx), .rd_data_o(g_rd),
      .wr_en_i(wr_en), .wr_idx_i(s1_q.gidx[IW-1:0]), .wr_data_i(g_nxt[CTR_BITS-1:0]),
      .clr_en_i(clr_en), .clr_idx_i(clr_idx_q)
   );

   sat_ctr_table #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .N_RD(NRD)) u_lpht (
      .clk_i(clk_i), .rd_idx_i(l_rd_idx), .rd_data_o(l_rd),
      .wr_en_i(wr_en), .wr_idx_i(s1_q.lidx[IW-1:0]), .wr_data_i(l_nxt[CTR_BITS-1:0]),
      .clr_en_i(clr_en), .clr_idx_i(clr_idx_q)
   );

   sat_ctr_table #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .N_RD(NRD)) u_chooser (
      .clk_i(clk_i), .rd_idx_i(l_rd_idx), .rd_data_o(c_rd),
      .wr_en_i(wr_en), .wr_idx_i(s1_q.lidx[IW-1:0]), .wr_data_i(c_nxt[CTR_BITS-1:0]),
      .clr_en_i(clr_en), .clr_idx_i(clr_idx_q)
   );

endmodule

// File: tb/tb_tournament_ghr_bp.sv
// Randomized and directed bench for tournament_ghr_bp against a table-level reference model.
module tb_tournament_ghr_bp;

   localparam int VLEN = 64;
   localparam int IPF  = 2;
   localparam int GB   = 8;
   localparam int ENT  = 256;
   localparam int CB   = 2;
   localparam int CMAX = (1 << CB) - 1;
   localparam int CINI = (1 << (CB - 1)) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush, debug;
   logic [VLEN-1:0] vpc;
   logic            fire, ptaken;
   logic [IPF-1:0]  pred_valid, pred_taken, pred_gtaken, pred_ltaken;
   logic [GB-1:0]   pred_ghr;
   logic            upd_valid, upd_ready;
   logic [VLEN-1:0] upd_pc;
   logic            upd_taken, upd_misp, upd_gt, upd_lt;
   logic [GB-1:0]   upd_ghr;

   always #5 clk = ~clk;

   tournament_ghr_bp #(
      .VLEN(VLEN), .INSTR_PER_FETCH(IPF), .GHR_BITS(GB), .ENTRIES(ENT), .CTR_BITS(CB)
   ) dut (
      .clk_i(clk), .rst_i(rst), .flush_bp_i(flush), .debug_mode_i(debug), .vpc_i(vpc),
      .pred_fire_i(fire), .pred_taken_i(ptaken), .pred_valid_o(pred_valid),
      .pred_taken_o(pred_taken), .pred_ghr_o(pred_ghr), .pred_gtaken_o(pred_gtaken),
      .pred_ltaken_o(pred_ltaken), .upd_valid_i(upd_valid), .upd_ready_o(upd_ready),
      .upd_pc_i(upd_pc), .upd_taken_i(upd_taken), .upd_mispredict_i(upd_misp),
      .upd_ghr_i(upd_ghr), .upd_gtaken_i(upd_gt), .upd_ltaken_i(upd_lt)
   );

   // Reference model: counter tables as plain integer arrays
   int gpht [ENT];
   int lpht [ENT];
   int chs  [ENT];
   bit m_run;
   int m_clr;
   int m_ghr;
   bit              p_v;
   logic [VLEN-1:0] p_pc;
   bit              p_taken, p_gt, p_lt;
   int              p_ghr;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [VLEN-1:0] pc);
      return int'((pc >> 1) % ENT);
   endfunction

   function automatic int sat(input int c, input bit up);
      if (up) return (c >= CMAX) ? CMAX : c + 1;
      return (c <= 0) ? 0 : c - 1;
   endfunction

   function automatic bit msb(input int c);
      return c >= (1 << (CB - 1));
   endfunction

   task automatic model_reset();
      m_run = 0; m_clr = 0; m_ghr = 0; p_v = 0;
   endtask

   task automatic model_apply();
      int li, gi;
      li = idx_of(p_pc);
      gi = li ^ p_ghr;
      gpht[gi] = sat(gpht[gi], p_taken);
      lpht[li] = sat(lpht[li], p_taken);
      if (p_gt != p_lt) chs[li] = sat(chs[li], p_gt == p_taken);
   endtask

   // Called at each rising edge with the inputs the DUT is sampling
   task automatic model_clock();
      bit acc;
      if (rst) begin
         model_reset();
         return;
      end
      acc = upd_valid && m_run;
      if (p_v && !flush) model_apply();
      p_v = 0;
      if (flush) begin
         m_run = 0; m_clr = 0; m_ghr = 0;
      end else if (!m_run) begin
         m_clr++;
         if (m_clr == ENT) begin
            m_run = 1;
            for (int i = 0; i < ENT; i++) begin
               gpht[i] = CINI; lpht[i] = CINI; chs[i] = CINI;
            end
         end
      end else begin
         if (acc && !debug) begin
            p_v = 1; p_pc = upd_pc; p_taken = upd_taken; p_gt = upd_gt; p_lt = upd_lt;
            p_ghr = int'(upd_ghr);
         end
         if (acc && !debug && upd_misp) m_ghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) % (1 << GB);
         else if (fire && !debug) m_ghr = ((m_ghr << 1) | int'(ptaken)) % (1 << GB);
      end
   endtask

   task automatic check_outputs();
      logic [IPF-1:0] eg, el, et;
      int li, gi;
      check_eq("upd_ready", 64'(upd_ready), 64'(m_run));
      check_eq("pred_valid", 64'(pred_valid), m_run ? 64'((1 << IPF) - 1) : 64'd0);
      check_eq("pred_ghr", 64'(pred_ghr), 64'(m_ghr));
      if (m_run) begin
         for (int i = 0; i < IPF; i++) begin
            li = idx_of(vpc + VLEN'(2 * i));
            gi = li ^ m_ghr;
            eg[i] = msb(gpht[gi]);
            el[i] = msb(lpht[li]);
            et[i] = msb(chs[li]) ? eg[i] : el[i];
         end
         check_eq("pred_gtaken", 64'(pred_gtaken), 64'(eg));
         check_eq("pred_ltaken", 64'(pred_ltaken), 64'(el));
         check_eq("pred_taken", 64'(pred_taken), 64'(et));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_inputs();
      flush = 0; debug = 0; fire = 0; ptaken = 0; upd_valid = 0; upd_taken = 0;
      upd_misp = 0; upd_gt = 0; upd_lt = 0; upd_ghr = '0;
   endtask

   task automatic update(input logic [VLEN-1:0] pc, input bit tk, input bit gt, input bit lt,
                         input logic [GB-1:0] gh, input bit misp);
      upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_gt = gt; upd_lt = lt;
      upd_ghr = gh; upd_misp = misp;
   endtask

   task automatic count_clear(input string tag);
      int n;
      n = 0;
      for (int k = 0; k < 400; k++) begin
         cycle();
         n++;
         if (upd_ready) break;
      end
      check_eq(tag, 64'(n), 64'(ENT));
   endtask

   function automatic logic [VLEN-1:0] rand_pc();
      if ($urandom_range(0, 9) == 0) return {$urandom, $urandom};
      return VLEN'(64'h1000 + 64'(2 * $urandom_range(0, 31)));
   endfunction

   task automatic random_phase(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         flush     = ($urandom_range(0, 499) == 0);
         debug     = ($urandom_range(0, 19) == 0);
         vpc       = rand_pc();
         fire      = $urandom_range(0, 1) == 1;
         ptaken    = $urandom_range(0, 1) == 1;
         upd_valid = $urandom_range(0, 9) < 7;
         upd_pc    = rand_pc();
         upd_taken = $urandom_range(0, 1) == 1;
         upd_misp  = $urandom_range(0, 9) < 3;
         upd_ghr   = GB'($urandom);
         upd_gt    = $urandom_range(0, 1) == 1;
         upd_lt    = $urandom_range(0, 1) == 1;
         cycle();
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      vpc = '0;
      upd_pc = '0;
      model_reset();
      repeat (3) cycle();
      rst = 0;
      count_clear("clr_len");

      // saturation: five taken updates at 0x1000 with GHR 0
      vpc = 64'h1000;
      repeat (5) begin
         update(64'h1000, 1, 0, 0, 8'h00, 0);
         cycle();
      end
      upd_valid = 0;
      repeat (2) cycle();
      check_eq("sat_pred", 64'(pred_taken[0]), 64'd1);
      check_eq("sat_gtaken", 64'(pred_gtaken[0]), 64'd1);
      update(64'h1000, 0, 0, 0, 8'h00, 0);
      cycle();
      upd_valid = 0;
      repeat (2) cycle();
      check_eq("sat_hold", 64'(pred_ltaken[0]), 64'd1);

      // back-to-back updates on one index exercise the stage-1 bypass
      vpc = 64'h2010;
      update(64'h2010, 1, 0, 0, 8'h00, 0);
      cycle();
      cycle();
      upd_valid = 0;
      cycle();
      update(64'h2010, 0, 0, 0, 8'h00, 0);
      cycle();
      upd_valid = 0;
      repeat (2) cycle();
      check_eq("bypass", 64'(pred_ltaken[0]), 64'd1);

      // speculative history then mispredict repair winning over a fire
      fire = 1;
      ptaken = 1; cycle();
      ptaken = 0; cycle();
      ptaken = 1; cycle();
      fire = 0;
      check_eq("ghr_fire", 64'(pred_ghr), 64'h05);
      update(64'h4000, 0, 0, 0, 8'h01, 1);
      fire = 1; ptaken = 1;
      cycle();
      idle_inputs();
      check_eq("ghr_misp", 64'(pred_ghr), 64'h02);

      // chooser moves toward global when only global was right
      vpc = 64'h3040;
      update(64'h3040, 1, 1, 0, 8'h00, 0);
      cycle();
      upd_valid = 0;
      repeat (2) cycle();
      check_eq("chooser_ltaken", 64'(pred_ltaken[0]), 64'd1);
      check_eq("chooser_flip", 64'(pred_taken[0]), 64'd0);
      update(64'h3040, 0, 1, 1, 8'h00, 0);
      cycle();
      upd_valid = 0;
      repeat (2) cycle();

      // flush while an update to entry 5 is in flight
      vpc = 64'h000A;
      update(64'h000A, 1, 0, 0, 8'h00, 0);
      cycle();
      upd_valid = 0;
      flush = 1;
      cycle();
      flush = 0;
      count_clear("flush_len");
      cycle();
      check_eq("flush_entry5_l", 64'(pred_ltaken[0]), 64'd0);
      check_eq("flush_entry5_t", 64'(pred_taken[0]), 64'd0);

      random_phase(1500);

      // asynchronous reset in the middle of traffic
      rst = 1;
      model_reset();
      repeat (2) cycle();
      rst = 0;
      random_phase(1500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
